// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and backend-resolution signals of the branch target buffer.
// The fetch/backend logic drives the master modport and the BTB implements the slave.
interface btb_assoc_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned OFFSET  = 2,
    parameter int unsigned N_SLOTS = 1
);
    logic                                  flush_i;
    logic                                  req_i;
    logic [XLEN-1:0]                       curr_pc_i;
    logic                                  valid_i;
    logic                                  del_entry_i;
    logic [XLEN-1:0]                       res_pc_i;
    logic [XLEN-1:0]                       res_target_i;
    logic                                  valid_o;
    logic [N_SLOTS-1:0]                    hit_o;
    logic [N_SLOTS-1:0][XLEN-OFFSET-1:0]   target_o;

    modport master (
        output flush_i, req_i, curr_pc_i, valid_i, del_entry_i, res_pc_i, res_target_i,
        input  valid_o, hit_o, target_o
    );

    modport slave (
        input  flush_i, req_i, curr_pc_i, valid_i, del_entry_i, res_pc_i, res_target_i,
        output valid_o, hit_o, target_o
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: N_SLOTS lookups per cycle with one-cycle latency,
// trained by branch resolution, with a per-set round-robin victim pointer.
module btb_assoc #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned OFFSET   = 2,
    parameter int unsigned BTB_BITS = 4,
    parameter int unsigned N_WAYS   = 2,
    parameter int unsigned N_SLOTS  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    btb_assoc_if.slave  bus
);
    localparam int unsigned SETS  = 1 << BTB_BITS;
    localparam int unsigned TAG_W = XLEN - BTB_BITS - OFFSET;
    localparam int unsigned TGT_W = XLEN - OFFSET;
    localparam int unsigned WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam logic [XLEN-1:0] SLOT_MASK = XLEN'(N_SLOTS - 1) << OFFSET;

    typedef logic [BTB_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [TGT_W-1:0]    tgt_t;
    typedef logic [WAY_W-1:0]    way_t;

    logic [N_WAYS-1:0] valid_q [SETS];
    logic [N_WAYS-1:0] valid_d [SETS];
    tag_t              tag_q   [SETS][N_WAYS];
    tag_t              tag_d   [SETS][N_WAYS];
    tgt_t              tgt_q   [SETS][N_WAYS];
    tgt_t              tgt_d   [SETS][N_WAYS];

    idx_t upd_idx;
    tag_t upd_tag;
    logic upd_match, upd_free, upd_en, del_en;
    way_t match_way, free_way, victim_way, wr_way;

    assign upd_idx = bus.res_pc_i[BTB_BITS+OFFSET-1:OFFSET];
    assign upd_tag = bus.res_pc_i[XLEN-1:BTB_BITS+OFFSET];
    assign upd_en  = bus.valid_i & ~bus.del_entry_i & ~bus.flush_i;
    assign del_en  = bus.valid_i &  bus.del_entry_i & ~bus.flush_i;

    // Tag match and lowest-index free way in the set addressed by the resolved PC.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        upd_match = 1'b0;
        match_way = '0;
        upd_free  = 1'b0;
        free_way  = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
                upd_match = 1'b1;
                match_way = way_t'(w);
            end
        end
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                upd_free = 1'b1;
                free_way = way_t'(w);
            end
        end
    end

    assign wr_way = upd_match ? match_way : (upd_free ? free_way : victim_way);

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (bus.flush_i) begin
            for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        end else if (upd_en) begin
            valid_d[upd_idx][wr_way] = 1'b1;
            tag_d[upd_idx][wr_way]   = upd_tag;
            tgt_d[upd_idx][wr_way]   = bus.res_target_i[XLEN-1:OFFSET];
        end else if (del_en && upd_match) begin
            valid_d[upd_idx][match_way] = 1'b0;
        end
    end

    // The pointer only moves when a full set has to evict; direct-mapped needs none.
    if (N_WAYS > 1) begin : g_ptr
        way_t ptr_q [SETS];
        way_t ptr_d [SETS];

        always_comb begin
            ptr_d = ptr_q;
            if (bus.flush_i) begin
                for (int s = 0; s < SETS; s++) ptr_d[s] = '0;
            end else if (upd_en && !upd_match && !upd_free) begin
                ptr_d[upd_idx] = ptr_q[upd_idx] + way_t'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        assign victim_way = ptr_q[upd_idx];
    end else begin : g_no_ptr
        assign victim_way = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/target storage is not reset; the valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    logic [XLEN-1:0]                 base_pc;
    logic                            out_valid_q, out_valid_d;
    logic [N_SLOTS-1:0]              out_hit_q, out_hit_d;
    logic [N_SLOTS-1:0][TGT_W-1:0]   out_tgt_q, out_tgt_d;

    assign base_pc = bus.curr_pc_i & ~SLOT_MASK;

    // Lookup reads the pre-update array, giving read-before-write with same-cycle training.
    always_comb begin : lookup_comb
        logic [XLEN-1:0] slot_pc;
        idx_t            slot_idx;
        tag_t            slot_tag;
        out_valid_d = bus.req_i & ~bus.flush_i;
        out_hit_d   = '0;
        out_tgt_d   = '0;
        slot_pc     = '0;
        slot_idx    = '0;
        slot_tag    = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_pc  = base_pc + (XLEN'(i) << OFFSET);
            slot_idx = slot_pc[BTB_BITS+OFFSET-1:OFFSET];
            slot_tag = slot_pc[XLEN-1:BTB_BITS+OFFSET];
            for (int w = 0; w < N_WAYS; w++) begin
                if (out_valid_d && valid_q[slot_idx][w] && tag_q[slot_idx][w] == slot_tag) begin
                    out_hit_d[i] = 1'b1;
                    out_tgt_d[i] = tgt_q[slot_idx][w];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= '0;
            out_tgt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_tgt_q   <= out_tgt_d;
        end
    end

    assign bus.valid_o  = out_valid_q;
    assign bus.hit_o    = out_hit_q;
    assign bus.target_o = out_tgt_q;

    // Sub-instruction address bits never select an entry.
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.curr_pc_i[OFFSET-1:0], bus.res_pc_i[OFFSET-1:0],
                               bus.res_target_i[OFFSET-1:0]};
endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: a 1-slot/2-way instance and a 2-slot/2-way instance.
module tb_btb_assoc;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned OFFSET = 2;
    localparam int unsigned TGT_W  = XLEN - OFFSET;

    typedef struct {
        string                     name;
        logic                      v;
        logic [1:0]                hit;
        logic [1:0][TGT_W-1:0]     tgt;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    btb_assoc_if #(.XLEN(XLEN), .OFFSET(OFFSET), .N_SLOTS(1)) bus_a ();
    btb_assoc_if #(.XLEN(XLEN), .OFFSET(OFFSET), .N_SLOTS(2)) bus_b ();

    btb_assoc #(.XLEN(XLEN), .OFFSET(OFFSET), .BTB_BITS(4), .N_WAYS(2), .N_SLOTS(1)) dut_a (
        .clk_i (clk), .rst_ni(rst_ni), .bus(bus_a)
    );
    btb_assoc #(.XLEN(XLEN), .OFFSET(OFFSET), .BTB_BITS(4), .N_WAYS(2), .N_SLOTS(2)) dut_b (
        .clk_i (clk), .rst_ni(rst_ni), .bus(bus_b)
    );

    // Scoreboard: each expectation pushed by a driver is compared one edge later.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            checks++;
            if ({bus_a.valid_o, bus_a.hit_o, bus_a.target_o} !== {ea.v, ea.hit[0], ea.tgt[0]}) begin
                errors++;
                $display("FAIL %s: got valid=%b hit=%b target=%h, expected valid=%b hit=%b target=%h",
                         ea.name, bus_a.valid_o, bus_a.hit_o, bus_a.target_o, ea.v, ea.hit[0], ea.tgt[0]);
            end
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            checks++;
            if ({bus_b.valid_o, bus_b.hit_o, bus_b.target_o} !== {eb.v, eb.hit, eb.tgt}) begin
                errors++;
                $display("FAIL %s: got valid=%b hit=%b target=%h/%h, expected valid=%b hit=%b target=%h/%h",
                         eb.name, bus_b.valid_o, bus_b.hit_o, bus_b.target_o[1], bus_b.target_o[0],
                         eb.v, eb.hit, eb.tgt[1], eb.tgt[0]);
            end
        end
    end

    task automatic clear_inputs();
        bus_a.flush_i = 0; bus_a.req_i = 0; bus_a.curr_pc_i = '0; bus_a.valid_i = 0;
        bus_a.del_entry_i = 0; bus_a.res_pc_i = '0; bus_a.res_target_i = '0;
        bus_b.flush_i = 0; bus_b.req_i = 0; bus_b.curr_pc_i = '0; bus_b.valid_i = 0;
        bus_b.del_entry_i = 0; bus_b.res_pc_i = '0; bus_b.res_target_i = '0;
    endtask

    // One cycle of stimulus on instance A; tgt is the expected byte target.
    task automatic drv_a(input string name, input logic req, input logic [31:0] pc,
                         input logic upd, input logic del, input logic [31:0] rpc,
                         input logic [31:0] rtgt, input logic flush,
                         input logic hit, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        bus_a.req_i = req; bus_a.curr_pc_i = pc; bus_a.valid_i = upd; bus_a.del_entry_i = del;
        bus_a.res_pc_i = rpc; bus_a.res_target_i = rtgt; bus_a.flush_i = flush;
        e.name   = name;
        e.v      = req & ~flush;
        e.hit    = {1'b0, e.v & hit};
        e.tgt    = '0;
        e.tgt[0] = (e.v && hit) ? tgt[31:2] : '0;
        q_a.push_back(e);
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic look_a(input string name, input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        drv_a(name, 1'b1, pc, 1'b0, 1'b0, '0, '0, 1'b0, hit, tgt);
    endtask

    task automatic upd_a(input string name, input logic [31:0] rpc, input logic [31:0] rtgt);
        drv_a(name, 1'b0, '0, 1'b1, 1'b0, rpc, rtgt, 1'b0, 1'b0, '0);
    endtask

    task automatic del_a(input string name, input logic [31:0] rpc);
        drv_a(name, 1'b0, '0, 1'b1, 1'b1, rpc, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drv_b(input string name, input logic req, input logic [31:0] pc,
                         input logic upd, input logic [31:0] rpc, input logic [31:0] rtgt,
                         input logic [1:0] hit, input logic [31:0] tgt0, input logic [31:0] tgt1);
        exp_t e;
        @(negedge clk);
        bus_b.req_i = req; bus_b.curr_pc_i = pc; bus_b.valid_i = upd;
        bus_b.res_pc_i = rpc; bus_b.res_target_i = rtgt;
        e.name   = name;
        e.v      = req;
        e.hit    = req ? hit : 2'b00;
        e.tgt[0] = e.hit[0] ? tgt0[31:2] : '0;
        e.tgt[1] = e.hit[1] ? tgt1[31:2] : '0;
        q_b.push_back(e);
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.valid_o, bus_a.hit_o, bus_a.target_o, bus_b.valid_o, bus_b.hit_o, bus_b.target_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h, expected all zero",
                     bus_a.valid_o, bus_a.hit_o, bus_a.target_o, bus_b.valid_o, bus_b.hit_o, bus_b.target_o);
        end
        rst_ni = 1'b1;
        look_a("reset_lookup_miss", 32'h100, 1'b0, '0);
    endtask

    task automatic test_update();
        drv_a("same_cycle_update_miss", 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 1'b0, '0);
        look_a("after_update_hit", 32'h100, 1'b1, 32'h200);
        upd_a("overwrite_a", 32'h100, 32'h280);
        look_a("overwrite_hit", 32'h100, 1'b1, 32'h280);
    endtask

    task automatic test_replace();
        upd_a("insert_b", 32'h200, 32'h1200);
        upd_a("insert_c", 32'h300, 32'h1300);
        look_a("a_evicted", 32'h100, 1'b0, '0);
        look_a("b_hit", 32'h200, 1'b1, 32'h1200);
        look_a("c_hit", 32'h300, 1'b1, 32'h1300);
        upd_a("insert_d", 32'h400, 32'h1400);
        look_a("b_evicted", 32'h200, 1'b0, '0);
        look_a("c_still_hit", 32'h300, 1'b1, 32'h1300);
        look_a("d_hit", 32'h400, 1'b1, 32'h1400);
    endtask

    task automatic test_delete();
        del_a("delete_d", 32'h400);
        look_a("d_deleted_miss", 32'h400, 1'b0, '0);
        look_a("c_after_delete", 32'h300, 1'b1, 32'h1300);
        del_a("delete_absent", 32'h200);
        look_a("c_after_absent_delete", 32'h300, 1'b1, 32'h1300);
        upd_a("insert_e_free_way", 32'h500, 32'h1500);
        upd_a("insert_f_victim", 32'h600, 32'h1600);
        look_a("c_evicted_ptr0", 32'h300, 1'b0, '0);
        look_a("e_hit", 32'h500, 1'b1, 32'h1500);
        look_a("f_hit", 32'h600, 1'b1, 32'h1600);
    endtask

    task automatic test_multi_slot();
        drv_b("b_insert_100", 1'b0, '0, 1'b1, 32'h100, 32'h3000, 2'b00, '0, '0);
        drv_b("b_insert_104", 1'b0, '0, 1'b1, 32'h104, 32'h3100, 2'b00, '0, '0);
        drv_b("b_lookup_104", 1'b1, 32'h104, 1'b0, '0, '0, 2'b11, 32'h3000, 32'h3100);
        drv_b("b_lookup_100", 1'b1, 32'h100, 1'b0, '0, '0, 2'b11, 32'h3000, 32'h3100);
        drv_b("b_lookup_108_miss", 1'b1, 32'h108, 1'b0, '0, '0, 2'b00, '0, '0);
    endtask

    task automatic test_flush();
        upd_a("insert_set1", 32'h104, 32'h2000);
        look_a("set1_hit", 32'h104, 1'b1, 32'h2000);
        drv_a("flush_with_update", 1'b1, 32'h104, 1'b1, 1'b0, 32'h108, 32'h2100, 1'b1, 1'b0, '0);
        look_a("flushed_104", 32'h104, 1'b0, '0);
        look_a("flushed_108", 32'h108, 1'b0, '0);
        look_a("flushed_500", 32'h500, 1'b0, '0);
        look_a("flushed_600", 32'h600, 1'b0, '0);
    endtask

    task automatic test_async_reset();
        upd_a("insert_700", 32'h700, 32'h1700);
        look_a("hit_700", 32'h700, 1'b1, 32'h1700);
        @(negedge clk);
        bus_a.req_i = 1'b1;
        bus_a.curr_pc_i = 32'h700;
        @(posedge clk);
        #2;
        checks++;
        if ({bus_a.valid_o, bus_a.hit_o} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_result: got valid=%b hit=%b, expected valid=1 hit=1",
                     bus_a.valid_o, bus_a.hit_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus_a.valid_o, bus_a.hit_o, bus_a.target_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_drop: got valid=%b hit=%b target=%h, expected all zero",
                     bus_a.valid_o, bus_a.hit_o, bus_a.target_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_pending: got valid=%b, expected valid=0", bus_a.valid_o);
        end
        @(negedge clk);
        clear_inputs();
        rst_ni = 1'b1;
        look_a("after_reset_700_miss", 32'h700, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_update();
        test_replace();
        test_delete();
        test_multi_slot();
        test_flush();
        test_async_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
